// File: rtl/polilock_if.sv
// Handshake bundle between the Polilock control unit, the UART receiver and the password memory.
// The master side is the environment (UART rx + memory); the slave side is the control unit.
interface polilock_if;
  logic       iniciar;
  logic       rx_pronto;
  logic [7:0] rx_dado;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (
    output iniciar, rx_pronto, rx_dado, mem_rdata,
    input  mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  iniciar, rx_pronto, rx_dado, mem_rdata,
    output mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/polilock_uc.sv
// Polilock control unit: command parsing, password verify/overwrite, failure counting and lockout.
// Optional inter-character timeout is enabled by defining POLILOCK_TIMEOUT_EN.
module polilock_uc #(
  parameter int PASS_LEN     = 10,
  parameter int MAX_TENT     = 3,
  parameter int BLOCK_CYCLES = 500_000_000,
  parameter int TIMEOUT_CYC  = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  polilock_if.slave  bus,
  output logic       acertou,
  output logic       errou,
  output logic       db_bloqueado,
  output logic [3:0] db_estado,
  output logic [3:0] db_contagem,
  output logic [2:0] db_falhas
);

  typedef enum logic [3:0] {
    S_INICIAL    = 4'd0,
    S_ESPERA_CMD = 4'd1,
    S_RECEBE_V   = 4'd2,
    S_RECEBE_M   = 4'd3,
    S_ACERTO     = 4'd4,
    S_ERRO       = 4'd5,
    S_GRAVADO    = 4'd6,
    S_BLOQUEADO  = 4'd7
  } state_t;

  localparam int          BLK_W    = $clog2(BLOCK_CYCLES + 1);
  localparam logic [3:0]  LAST_IDX = 4'(PASS_LEN - 1);
  localparam logic [7:0]  CMD_V    = 8'h76;
  localparam logic [7:0]  CMD_M    = 8'h6D;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [2:0]         falhas_q, falhas_d;
  logic               mismatch_q, mismatch_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               do_fail;
  logic               mis_new;
  logic [2:0]         fail_cnt;
  logic               tmo_hit;

`ifdef POLILOCK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  // Counts only while waiting for a character; any other state leaves it cleared.
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_ESPERA_CMD || state_q == S_RECEBE_V || state_q == S_RECEBE_M) && !bus.rx_pronto)
      tmo_d = tmo_q + 1'b1;
  end
`else
  wire unused_tmo_cfg = (TIMEOUT_CYC == 0);
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_INICIAL;
      idx_q      <= '0;
      falhas_q   <= '0;
      mismatch_q <= 1'b0;
      blk_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      falhas_q   <= falhas_d;
      mismatch_q <= mismatch_d;
      blk_q      <= blk_d;
    end
  end

  assign mis_new  = mismatch_q | (bus.rx_dado != bus.mem_rdata);
  assign fail_cnt = falhas_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    falhas_d   = falhas_q;
    mismatch_d = mismatch_q;
    blk_d      = '0;
    bus.mem_we = 1'b0;
    do_fail    = 1'b0;

    case (state_q)
      S_INICIAL, S_ACERTO, S_ERRO, S_GRAVADO: begin
        if (bus.iniciar) begin
          state_d    = S_ESPERA_CMD;
          idx_d      = '0;
          mismatch_d = 1'b0;
        end
      end
      S_ESPERA_CMD: begin
        if (bus.rx_pronto) begin
          if (bus.rx_dado == CMD_V)      state_d = S_RECEBE_V;
          else if (bus.rx_dado == CMD_M) state_d = S_RECEBE_M;
        end else if (tmo_hit) begin
          state_d = S_INICIAL;
        end
      end
      S_RECEBE_V: begin
        if (bus.rx_pronto) begin
          if (idx_q == LAST_IDX) begin
            if (mis_new) do_fail = 1'b1;
            else begin
              state_d  = S_ACERTO;
              falhas_d = '0;
            end
          end else begin
            idx_d      = idx_q + 4'd1;
            mismatch_d = mis_new;
          end
        end else if (tmo_hit) begin
          do_fail = 1'b1;
        end
      end
      S_RECEBE_M: begin
        bus.mem_we = bus.rx_pronto;
        if (bus.rx_pronto) begin
          if (idx_q == LAST_IDX) state_d = S_GRAVADO;
          else                   idx_d   = idx_q + 4'd1;
        end else if (tmo_hit) begin
          state_d = S_INICIAL;
        end
      end
      S_BLOQUEADO: begin
        blk_d = blk_q + 1'b1;
        if (blk_q == BLK_W'(BLOCK_CYCLES - 1)) state_d = S_INICIAL;
      end
      default: state_d = S_INICIAL;
    endcase

    // The failure that reaches MAX_TENT diverts to lockout and restarts the count.
    if (do_fail) begin
      if (fail_cnt == 3'(MAX_TENT)) begin
        state_d  = S_BLOQUEADO;
        falhas_d = '0;
      end else begin
        state_d  = S_ERRO;
        falhas_d = fail_cnt;
      end
    end
  end

  assign bus.mem_addr  = idx_q;
  assign bus.mem_wdata = bus.rx_dado;

  assign acertou      = (state_q == S_ACERTO);
  assign errou        = (state_q == S_ERRO);
  assign db_bloqueado = (state_q == S_BLOQUEADO);
  assign db_estado    = state_q;
  assign db_contagem  = idx_q;
  assign db_falhas    = falhas_q;

endmodule
